// File: rtl/mulalu.sv
// Multi-cycle MIPS MULT/MULTU/DIV/DIVU unit in EX, with HI/LO write strobes and an EX stall.
// Optional MULALU_EARLY_TERM_EN: divides with |a| < |b| (b != 0) skip the iterative loop.
module mulalu #(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [4:0]  mulalu_func,
    input  logic        mulalu_sign,
    input  logic [31:0] source_a,
    input  logic [31:0] source_b,
    input  logic        flush,
    input  logic        pipe_hold,
    output logic        stall,
    output logic        busy,
    output logic        hi_write,
    output logic [31:0] hi_write_data,
    output logic        lo_write,
    output logic [31:0] lo_write_data
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 6;
    localparam logic [4:0] FUNC_MUL = 5'h18;
    localparam logic [4:0] FUNC_DIV = 5'h1A;

`ifdef MULALU_EARLY_TERM_EN
    localparam bit EARLY_TERM = 1'b1;
`else
    localparam bit EARLY_TERM = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [W-1:0]    divisor_q, divisor_d;
    logic [W-1:0]    raw_a_q, raw_a_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic            is_div_q, is_div_d;
    logic            div0_q, div0_d;
    logic [W-1:0]    hi_data_q, hi_data_d;
    logic [W-1:0]    lo_data_q, lo_data_d;
    logic            hi_write_q, hi_write_d;
    logic            lo_write_q, lo_write_d;

    logic            start;
    logic            early;
    logic [W-1:0]    mag_a, mag_b;
    logic [W:0]      rem_sh, rem_sub;
    logic            qbit;
    logic [2*W-1:0]  div_step;
    logic [2*W-1:0]  prod_fix;
    logic [W-1:0]    quo_fix, rem_fix, fix_hi, fix_lo;

    // Operand magnitudes and one restoring-divide step (acc = {remainder, dividend/quotient}).
    always_comb begin
        start    = (state_q == S_IDLE) && !flush &&
                   ((mulalu_func == FUNC_MUL) || (mulalu_func == FUNC_DIV));
        mag_a    = (mulalu_sign && source_a[W-1]) ? (~source_a + 32'd1) : source_a;
        mag_b    = (mulalu_sign && source_b[W-1]) ? (~source_b + 32'd1) : source_b;
        early    = EARLY_TERM && (mulalu_func == FUNC_DIV) && (mag_b != '0) && (mag_a < mag_b);
        rem_sh   = {acc_q[2*W-1:W], acc_q[W-1]};
        rem_sub  = rem_sh - {1'b0, divisor_q};
        qbit     = ~rem_sub[W];
        div_step = {(qbit ? rem_sub[W-1:0] : rem_sh[W-1:0]), acc_q[W-2:0], qbit};
    end

    // Sign correction; divide-by-zero returns the raw dividend in HI.
    always_comb begin
        prod_fix = qneg_q ? (~acc_q + 64'd1) : acc_q;
        quo_fix  = qneg_q ? (~acc_q[W-1:0] + 32'd1) : acc_q[W-1:0];
        rem_fix  = rneg_q ? (~acc_q[2*W-1:W] + 32'd1) : acc_q[2*W-1:W];
        fix_hi   = prod_fix[2*W-1:W];
        fix_lo   = prod_fix[W-1:0];
        if (is_div_q) begin
            fix_hi = div0_q ? raw_a_q : rem_fix;
            fix_lo = div0_q ? 32'hFFFF_FFFF : quo_fix;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        divisor_d  = divisor_q;
        raw_a_d    = raw_a_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        is_div_d   = is_div_q;
        div0_d     = div0_q;
        hi_data_d  = hi_data_q;
        lo_data_d  = lo_data_q;
        hi_write_d = 1'b0;
        lo_write_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d     = early ? {mag_a, 32'h0} : {32'h0, mag_a};
                    divisor_d = mag_b;
                    raw_a_d   = source_a;
                    qneg_d    = mulalu_sign && (source_a[W-1] ^ source_b[W-1]);
                    rneg_d    = mulalu_sign && source_a[W-1];
                    is_div_d  = (mulalu_func == FUNC_DIV);
                    div0_d    = (source_b == '0);
                    cnt_d     = '0;
                    if (mulalu_func == FUNC_MUL) begin
                        state_d = S_MUL;
                    end else begin
                        state_d = early ? S_FIX : S_DIV;
                    end
                end
            end
            S_MUL: begin
                // Product formed in the first busy cycle and carried to FIX.
                if (cnt_q == '0) begin
                    acc_d = 64'(acc_q[W-1:0]) * 64'(divisor_q);
                end
                if (cnt_q == CW'(MUL_LAT - 1)) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DIV: begin
                acc_d = div_step;
                if (cnt_q == CW'(W - 1)) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_FIX: begin
                hi_data_d  = fix_hi;
                lo_data_d  = fix_lo;
                hi_write_d = 1'b1;
                lo_write_d = 1'b1;
                state_d    = S_DONE;
            end
            S_DONE: begin
                if (!pipe_hold) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Flush kills the instruction in every state and suppresses any pending write.
        if (flush) begin
            state_d    = S_IDLE;
            hi_write_d = 1'b0;
            lo_write_d = 1'b0;
            hi_data_d  = hi_data_q;
            lo_data_d  = lo_data_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            divisor_q  <= '0;
            raw_a_q    <= '0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            is_div_q   <= 1'b0;
            div0_q     <= 1'b0;
            hi_data_q  <= '0;
            lo_data_q  <= '0;
            hi_write_q <= 1'b0;
            lo_write_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            divisor_q  <= divisor_d;
            raw_a_q    <= raw_a_d;
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
            is_div_q   <= is_div_d;
            div0_q     <= div0_d;
            hi_data_q  <= hi_data_d;
            lo_data_q  <= lo_data_d;
            hi_write_q <= hi_write_d;
            lo_write_q <= lo_write_d;
        end
    end

    assign stall         = start || (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
    assign busy          = (state_q != S_IDLE);
    assign hi_write      = hi_write_q;
    assign lo_write      = lo_write_q;
    assign hi_write_data = hi_data_q;
    assign lo_write_data = lo_data_q;

endmodule

// File: doc/mulalu.md
Name: mulalu

Overview:
- Multi-cycle multiply/divide unit in the EX stage, directly downstream of the single-cycle ALU.
- Consumes the ALU's multiply/divide function code, sign select and both source operands.
- Produces HI/LO write requests and a stall that holds EX while an operation is in flight.
- Implements MIPS MULT/MULTU/DIV/DIVU semantics.

Parameters:
- MUL_LAT, 2, number of busy cycles after capture for multiply, legal range 1..4 (product pipelined across the cycles).

Ports:
- clk  in  1  Clock.
- resetn  in  1  Asynchronous, active-low reset.
- mulalu_func  in  5  Function code: FUNC_MUL starts a multiply, FUNC_DIV starts a divide, 5'b00000 means no operation.
- mulalu_sign  in  1  1 = signed operation, 0 = unsigned.
- source_a  in  32  Multiplicand/dividend; sampled only in the start cycle.
- source_b  in  32  Multiplier/divisor; sampled only in the start cycle.
- flush  in  1  Kills the EX instruction (exception/eret); aborts the operation.
- pipe_hold  in  1  Another hazard is holding EX this cycle.
- stall  out  1  Holds EX; combinational.
- busy  out  1  State is not IDLE.
- hi_write  out  1  One-cycle HI write strobe.
- hi_write_data  out  32  HI result.
- lo_write  out  1  One-cycle LO write strobe.
- lo_write_data  out  32  LO result.

Behaviour:
- Reset (async, resetn=0):
  - State is IDLE; counter is 0.
  - stall, busy, hi_write and lo_write are 0.
  - hi_write_data and lo_write_data are 32'h0.
- States: IDLE, MUL, DIV, FIX, DONE.
- Start condition: start = (state==IDLE) & ~flush & (mulalu_func==FUNC_MUL | mulalu_func==FUNC_DIV).
- stall = start | (state is MUL, DIV or FIX). Stall is 0 in DONE.
- Timing is counted from start cycle 0; operands are captured at the edge ending cycle 0.
- Operand preparation:
  - Signed: take the absolute value of each operand and record sign_q = a[31]^b[31] and sign_r = a[31].
  - Unsigned: operands pass unchanged.
- MUL:
  - Runs cycles 1..MUL_LAT computing the unsigned 64-bit product of the magnitudes, then goes to FIX.
- DIV (radix-2 restoring):
  - 32 iterations in cycles 1..32, one quotient bit per cycle, then goes to FIX.
- FIX (1 cycle) applies the sign correction:
  - Multiply: negate the 64-bit product if sign_q.
  - Divide: negate the quotient if sign_q; negate the remainder if sign_r.
  - Results are registered into the output data regs; then goes to DONE.
- Total stall cycles: multiply MUL_LAT+2 (cycles 0..MUL_LAT+1); divide 34 (cycles 0..33).
- DONE:
  - hi_write and lo_write are 1 only in the first DONE cycle.
  - Multiply: HI = product[63:32], LO = product[31:0]. Divide: HI = remainder, LO = quotient.
  - Stays in DONE while pipe_hold=1 (no repeat write).
  - Goes to IDLE on the first cycle with pipe_hold=0.
  - Start is ignored in DONE, so the same EX instruction never restarts.
- Output data regs hold their last value outside DONE.
- Divide by zero: LO = 32'hFFFFFFFF, HI = source_a (raw), independent of sign. Same latency.
- Signed 32'h80000000 / 32'hFFFFFFFF: LO = 32'h80000000, HI = 0. No trap.
- flush:
  - In any state, goes to IDLE next edge with no HI/LO write.
  - In DONE the write has already occurred; flush only returns to IDLE.
  - flush in the same cycle as a would-be start blocks the start.
- Async reset mid-operation: discards all state; no write is produced afterwards.
- mulalu_func with any other value in IDLE: no action, stall=0.

Optional Feature:
- Macro: MULALU_EARLY_TERM_EN.
- Defined:
  - In cycle 0 of a divide, if |a| < |b| (unsigned compare of the magnitudes) and b != 0, skip DIV and go to FIX.
  - Result: quotient 0, remainder = |a|, sign-fixed as normal.
  - Divide stall is 2 cycles (cycles 0..1); DONE in cycle 2.
- Undefined: every divide takes the full 34 stall cycles.

Test Plan:
- Unsigned multiply: a=32'hFFFFFFFF, b=32'h2, MUL_LAT=2 -> stall for cycles 0..3; in cycle 4, HI=32'h1 and LO=32'hFFFFFFFE with hi_write=lo_write=1.
- Signed divide: a=-7 (32'hFFFFFFF9), b=2 -> stall 34 cycles; then LO=32'hFFFFFFFD (-3), HI=32'hFFFFFFFF (-1).
- Divide by zero: a=32'h1234, b=0, signed -> LO=32'hFFFFFFFF, HI=32'h1234 after 34 stall cycles.
- pipe_hold=1 for 3 cycles at DONE -> exactly one write strobe, stall=0 throughout DONE, no restart although mulalu_func is still FUNC_DIV; IDLE after pipe_hold drops.
- flush in cycle 10 of a divide -> IDLE next cycle, no hi_write/lo_write, stall=0. A new start two cycles later completes correctly.
- With MULALU_EARLY_TERM_EN defined: unsigned a=5, b=9 -> stall cycles 0..1; in cycle 2, LO=0 and HI=5. Without the macro, same stimulus takes 34 stall cycles and gives the same result.
